// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the counter bank: direction encoding, wrap limit, load clamp.
package cnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest count value; 33 bits so WIDTH=32 with natural wrap is representable.
  function automatic logic [32:0] cnt_max(input int width, input longint modulo);
    if (modulo != 0) begin
      return 33'(modulo - 1);
    end
    return (33'd1 << width) - 33'd1;
  endfunction

  function automatic logic [32:0] cnt_sat(input logic [32:0] value, input logic [32:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/cnt_chan.sv
// One counter channel: up/down count wrapping at MAX, one-cycle tc pulse on wrap, sticky wrapped flag.
// Priority per edge: clr > load > en > hold; all outputs registered (one-cycle latency).
module cnt_chan
  import cnt_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [32:0] MAX   = cnt_max(32, 0)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrapped
);

  // Compare at WIDTH+1 bits so MAX = 2^WIDTH-1 needs no special case.
  localparam logic [WIDTH:0] MAX_X = MAX[WIDTH:0];

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             wrapped_nxt;

  always_comb begin
    cnt_x       = {1'b0, cnt};
    cnt_nxt     = cnt;
    tc_nxt      = 1'b0;
    wrapped_nxt = wrapped;
    if (clr) begin
      cnt_nxt     = '0;
      wrapped_nxt = 1'b0;
    end else if (load) begin
      cnt_nxt = WIDTH'(cnt_sat(33'(load_val), MAX));
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (cnt_x == MAX_X) begin
          cnt_nxt = '0;
          tc_nxt  = 1'b1;
        end else begin
          cnt_nxt = WIDTH'(cnt_x + 1'b1);
        end
      end else begin
        if (cnt_x == '0) begin
          cnt_nxt = WIDTH'(MAX_X);
          tc_nxt  = 1'b1;
        end else begin
          cnt_nxt = WIDTH'(cnt_x - 1'b1);
        end
      end
    end
    if (tc_nxt) begin
      wrapped_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      tc      <= tc_nxt;
      wrapped <= wrapped_nxt;
    end
  end

endmodule

// File: rtl/cnt_bank.sv
// Bank of CHANNELS independent up/down counters with programmable modulo; one-cycle latency, no backpressure.
// Define CNT_SNAPSHOT_EN to add the snap strobe and coherent snap_cnt capture of all channels.
module cnt_bank
  import cnt_pkg::*;
#(
  parameter int     WIDTH    = 32,
  parameter int     CHANNELS = 4,
  parameter longint MODULO   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS*WIDTH-1:0] cnt,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       wrapped
`ifdef CNT_SNAPSHOT_EN
  ,
  input  logic                      snap,
  output logic [CHANNELS*WIDTH-1:0] snap_cnt
`endif
);

  localparam logic [32:0] MAX = cnt_max(WIDTH, MODULO);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    cnt_chan #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .en       (en[i]),
      .dir      (dir[i]),
      .cnt      (cnt[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .wrapped  (wrapped[i])
    );
  end

`ifdef CNT_SNAPSHOT_EN
  // Captures the pre-update counts of every channel on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_cnt <= '0;
    end else if (snap) begin
      snap_cnt <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_cnt_bank.sv
// Scoreboard bench for cnt_bank (WIDTH=4, CHANNELS=2, MODULO=10); snapshot checked when CNT_SNAPSHOT_EN is defined.
module tb_cnt_bank;

  logic       clk;
  logic       rst;
  logic [1:0] clr;
  logic [1:0] load;
  logic [7:0] load_val;
  logic [1:0] en;
  logic [1:0] dir;
  logic [7:0] cnt;
  logic [1:0] tc;
  logic [1:0] wrapped;
  logic       snap;
  logic [7:0] snap_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] c;
    logic [1:0] t;
    logic [1:0] w;
    logic [7:0] s;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  event async_ev;

  // Entries are {ch1, ch0}; ch0 counts up, ch1 counts down from reset.
  logic [7:0] cnt_tab [12] = '{8'h91, 8'h82, 8'h73, 8'h64, 8'h55, 8'h46,
                               8'h37, 8'h28, 8'h19, 8'h00, 8'h91, 8'h82};
  logic [1:0] tc_tab  [12] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
  logic [1:0] wr_tab  [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};

  cnt_bank #(
    .WIDTH    (4),
    .CHANNELS (2),
    .MODULO   (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (dir),
    .cnt      (cnt),
    .tc       (tc),
    .wrapped  (wrapped)
`ifdef CNT_SNAPSHOT_EN
    ,
    .snap     (snap),
    .snap_cnt (snap_cnt)
`endif
  );

`ifndef CNT_SNAPSHOT_EN
  assign snap_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [1:0] c, input logic [1:0] l,
                       input logic [7:0] lv, input logic [1:0] e, input logic [1:0] d,
                       input logic s, input logic [7:0] xc, input logic [1:0] xt,
                       input logic [1:0] xw, input logic [7:0] xs, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; load = l; load_val = lv; en = e; dir = d; snap = s;
    x.c = xc; x.t = xt; x.w = xw; x.s = xs; x.nm = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per edge (or per async event), sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cnt !== e.c || tc !== e.t || wrapped !== e.w) begin
          errors++;
          $display("FAIL %s: got cnt=%h tc=%b wrapped=%b, want cnt=%h tc=%b wrapped=%b",
                   e.nm, cnt, tc, wrapped, e.c, e.t, e.w);
        end
`ifdef CNT_SNAPSHOT_EN
        checks++;
        if (snap_cnt !== e.s) begin
          errors++;
          $display("FAIL %s_snap: got snap_cnt=%h, want %h", e.nm, snap_cnt, e.s);
        end
`endif
      end
    end
  end

  initial begin
    exp_t x;
    rst = 1'b1; clr = '0; load = '0; load_val = '0; en = '0; dir = '0; snap = 1'b0;
    #1 rst = 1'b0;

    // Held in reset with enables high: nothing moves.
    drive(0, 2'b00, 2'b00, 8'h00, 2'b11, 2'b11, 0, 8'h00, 2'b00, 2'b00, 8'h00, "reset");

    // ch0 up, ch1 down from zero for 12 edges.
    for (int k = 0; k < 12; k++)
      drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b01, 0,
            cnt_tab[k], tc_tab[k], wr_tab[k], 8'h00, $sformatf("run%0d", k));

    // Direction flips with en held, including flips at 0 and MAX.
    drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b10, 0, 8'h91, 2'b00, 2'b11, 8'h00, "dir_flip");
    drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b10, 0, 8'h00, 2'b10, 2'b11, 8'h00, "dir_up_wrap");
    drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b10, 0, 8'h19, 2'b01, 2'b11, 8'h00, "dir_down_wrap");
    drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b01, 0, 8'h00, 2'b01, 2'b11, 8'h00, "dir_flip_max");

    // ch0 loads 13 (clamped to 9); ch1 loads 5 with en high (load wins).
    drive(1, 2'b00, 2'b11, 8'h5D, 2'b10, 2'b10, 0, 8'h59, 2'b00, 2'b11, 8'h00, "load_clamp");
    drive(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 0, 8'h59, 2'b00, 2'b11, 8'h00, "hold");

    // clr beats load and en on ch0; ch1 keeps counting.
    drive(1, 2'b00, 2'b11, 8'h77, 2'b00, 2'b00, 0, 8'h77, 2'b00, 2'b11, 8'h00, "load7");
    drive(1, 2'b01, 2'b01, 8'h33, 2'b11, 2'b11, 0, 8'h80, 2'b00, 2'b10, 8'h00, "clr_prio");

    // Bring ch0 to 6 with wrapped set, then reset between edges.
    drive(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 0, 8'h89, 2'b01, 2'b11, 8'h00, "down_wrap");
    drive(1, 2'b00, 2'b01, 8'h06, 2'b00, 2'b00, 0, 8'h86, 2'b00, 2'b11, 8'h00, "load6");
    @(negedge clk);
    #2;
    rst = 1'b0; en = 2'b11; dir = 2'b11; load = '0;
    x.c = 8'h00; x.t = 2'b00; x.w = 2'b00; x.s = 8'h00; x.nm = "async_rst";
    exp_q.push_back(x);
    -> async_ev;
    drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b11, 0, 8'h11, 2'b00, 2'b00, 8'h00, "resume");

    // Snapshot of {8,3} while live counts move on; clr does not touch it.
    drive(1, 2'b00, 2'b11, 8'h83, 2'b00, 2'b00, 0, 8'h83, 2'b00, 2'b00, 8'h00, "snap_setup");
    drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b11, 1, 8'h94, 2'b00, 2'b00, 8'h83, "snap_take");
    drive(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b11, 0, 8'h05, 2'b10, 2'b10, 8'h83, "snap_hold");
    drive(1, 2'b11, 2'b00, 8'h00, 2'b00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 8'h83, "snap_clr");

    @(negedge clk);
    clr = '0; en = '0; snap = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_bank.md
# cnt_bank

Parametrised multi-channel counter bank that replaces single free-running counters in the lab designs. Each channel counts up or down, with its own enable, synchronous clear and parallel load. Each channel wraps at a programmable modulo and pulses a terminal-count flag on every wrap. An optional snapshot register captures all channels coherently on one edge for readout by the display/debug path.

## Interface
- WIDTH, 32, bit width of each channel counter (2..32)
- CHANNELS, 4, number of independent channels (1..16)
- MODULO, 0, count range per channel; 0 = natural 2^WIDTH wrap, else channels count 0..MODULO-1 (2 ≤ MODULO ≤ 2^WIDTH)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- clr  in  CHANNELS  per-channel synchronous clear
- load  in  CHANNELS  per-channel parallel load strobe
- load_val  in  CHANNELS*WIDTH  load values, channel i at [i*WIDTH +: WIDTH]
- en  in  CHANNELS  per-channel count enable
- dir  in  CHANNELS  count direction, 1 = up, 0 = down
- cnt  out  CHANNELS*WIDTH  live registered count, same packing as load_val
- tc  out  CHANNELS  one-cycle terminal-count pulse on wrap
- wrapped  out  CHANNELS  sticky wrap flag, set by tc, cleared by clr
- snap  in  1  snapshot strobe (only with CNT_SNAPSHOT_EN)
- snap_cnt  out  CHANNELS*WIDTH  snapshot of all channels (only with CNT_SNAPSHOT_EN)

## Operation
- MAX = MODULO-1 if MODULO≠0, else 2^WIDTH-1.
- Per-channel priority per edge: clr > load > en > hold.
  - clr: count←0, wrapped←0, tc←0.
  - load: count←min(load_val_i, MAX). tc←0, wrapped unchanged.
  - en, dir=1: count = MAX → 0 with tc←1, else count+1.
  - en, dir=0: count = 0 → MAX with tc←1, else count−1.
  - otherwise: hold, tc←0.
- wrapped←1 whenever tc is set; it holds until clr or reset.
- The increment/decrement is evaluated at WIDTH+1 bits internally. The compare against MAX is exact; no truncation artefacts when MODULO = 2^WIDTH.
- Channels are fully independent. No cross-channel carry.
- Unlike the earlier counter, cnt always shows the true count. It is not forced to 0 when en is low.

## Timing
- Reset (rst low, asynchronous): cnt=0, tc=0, wrapped=0, snap_cnt=0 on every channel, immediately and regardless of clk.
- Release of rst is synchronous to clk. The first count occurs on the first rising edge with rst high and en set.
- Latency is one cycle. Inputs sampled at edge k are reflected on cnt/tc/wrapped after edge k.
- tc is high for exactly the cycle in which cnt shows the wrapped value (0 going up, MAX going down).
- Continuous en with dir=1 from 0 gives tc every MAX+1 cycles.
- Changing dir with en held takes effect on the next edge, with no dead cycle.
- A dir change at 0 or MAX wraps if the new direction requires it.
- load and en in the same cycle: load wins, no count, no tc.
- clr and load in the same cycle: clr wins.
- Reset asserted mid-count: all state drops to 0 asynchronously, and any pending tc is lost.

## Configuration
- Macro: CNT_SNAPSHOT_EN.
- Defined:
  - snap and snap_cnt ports exist.
  - On an edge with snap=1, snap_cnt←cnt for all channels, using the values visible in that cycle (pre-update).
  - snap_cnt holds until the next snap. It is unaffected by clr or load.
- Undefined: snap and snap_cnt ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package cnt_pkg:
  - DIR_UP/DIR_DOWN constants.
  - Function cnt_max(WIDTH, MODULO) returning MAX.
  - Function cnt_sat(value, max) for load clamping.
- Sub-module cnt_chan: a single channel (count register, tc, wrapped) with WIDTH/MAX parameters. cnt_bank instantiates CHANNELS copies in a generate loop.
- cnt_bank owns packing/unpacking and the optional snapshot register.

## Test plan
- WIDTH=4, MODULO=10, ch0 en=1 dir=1 from reset for 12 cycles → cnt 1..9,0,1,2. tc high only in the cycle cnt=0, then wrapped=1.
- Same config, dir=0 from 0 → first edge gives cnt=9 with tc=1, then 8,7.
- load_val=13 with MODULO=10 → cnt=9 (clamped). load=1 and en=1 together with load_val=5 → cnt=5, tc=0.
- clr, load and en all high with cnt=7 → cnt=0, wrapped=0, tc=0.
- rst pulled low between edges while cnt=6 and wrapped=1 → cnt=0 and wrapped=0 before the next edge. Counting resumes from 1 after release.
- CNT_SNAPSHOT_EN, CHANNELS=2, ch0=3, ch1=8 both counting up, snap=1 for one cycle → snap_cnt holds {8,3} while the live counts advance to {9,4}.
